// File: rtl/shift_pkg.sv
// Shared definitions for the shift-unit issue front end.
// Holds the decoded op encoding, the shifter control codes and the amount
// saturation value used when the amount comes from a register.
package shift_pkg;

    // Width the downstream shifter is built for.
    localparam int unsigned SH_DATA_W = 16;

    // Decoded op field; any code with the top bit set is illegal.
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam int unsigned OP_ILLEGAL_BIT = 2;

    // Register amounts above this clamp to it: a full-width shift.
    localparam int unsigned SHAMT_SAT = 16;

    // Shifter control codes, identical to the low two op bits.
    typedef enum logic [1:0] {
        CTRL_SLL = 2'b00,
        CTRL_SRL = 2'b01,
        CTRL_SRA = 2'b10,
        CTRL_ROR = 2'b11
    } sh_ctrl_e;

endpackage

// File: rtl/pipe_slot.sv
// Generic single-entry valid/ready register slot.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   valid_i/ready_o     upstream handshake; ready_o is combinational from ready_i
//   data_i              payload captured on an upstream transfer
//   valid_o/ready_i     downstream handshake
//   data_o              registered payload
// A slot that is consumed and refilled in the same cycle stays valid.
module pipe_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;
    logic             slot_free;

    always_comb begin
        slot_free = !valid_q || ready_i;
        valid_d   = valid_q;
        data_d    = data_q;
        if (valid_i && slot_free) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = slot_free;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/shift_issue.sv
// Execute-stage front end for the 16-bit shift unit.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          decode handshake
//   in_op, in_use_imm, in_imm  op code and amount source
//   in_rs_val, in_rt_val       value to shift, register amount
//   in_rd                      destination register
//   sh_data/sh_shift/sh_control registered shifter inputs (slot S1)
//   sh_out                     shifter combinational result
//   wb_valid/wb_ready          writeback handshake (slot S2)
//   wb_data, wb_rd             result and destination
//   err_illegal                one-cycle pulse after accepting an illegal op
//   retired                    wrapping count of results consumed by writeback
module shift_issue
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = SH_DATA_W,
    parameter int unsigned AMT_W  = 16,
    parameter int unsigned RD_W   = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_use_imm,
    input  logic [3:0]        in_imm,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [RD_W-1:0]   in_rd,
    output logic [DATA_W-1:0] sh_data,
    output logic [AMT_W-1:0]  sh_shift,
    output logic [1:0]        sh_control,
    input  logic [DATA_W-1:0] sh_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  retired
);

    // Slot S1 state.
    logic              s1_valid_d, s1_valid_q;
    logic [DATA_W-1:0] sh_data_d, sh_data_q;
    logic [AMT_W-1:0]  sh_shift_d, sh_shift_q;
    sh_ctrl_e          sh_control_d, sh_control_q;
    logic [RD_W-1:0]   s1_rd_d, s1_rd_q;

    logic              err_d, err_q;
    logic [CNT_W-1:0]  retired_d, retired_q;

    logic              s2_free;
    logic              s1_adv;
    logic              accept;
    logic              op_legal;
    logic [AMT_W-1:0]  amt_reg;
    logic [AMT_W-1:0]  amt_sel;

    // Register-sourced amount: linear shifts saturate at a full-width shift,
    // rotates wrap modulo the data width.
    always_comb begin
        amt_reg = '0;
        case (in_op)
            OP_SLL, OP_SRL, OP_SRA: begin
                if (in_rt_val > DATA_W'(SHAMT_SAT)) begin
                    amt_reg = AMT_W'(SHAMT_SAT);
                end else begin
                    amt_reg = AMT_W'(in_rt_val);
                end
            end
            OP_ROR:  amt_reg = AMT_W'(in_rt_val[3:0]);
            default: amt_reg = '0;
        endcase
    end

    assign amt_sel  = in_use_imm ? AMT_W'(in_imm) : amt_reg;
    assign op_legal = !in_op[OP_ILLEGAL_BIT];

    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        sh_data_d    = sh_data_q;
        sh_shift_d   = sh_shift_q;
        sh_control_d = sh_control_q;
        s1_rd_d      = s1_rd_q;
        err_d        = accept && !op_legal;
        retired_d    = retired_q;

        // Shifter inputs only move on a legal accept, so they stay put while held.
        if (accept && op_legal) begin
            s1_valid_d   = 1'b1;
            sh_data_d    = in_rs_val;
            sh_shift_d   = amt_sel;
            sh_control_d = sh_ctrl_e'(in_op[1:0]);
            s1_rd_d      = in_rd;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (wb_valid && wb_ready) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            sh_data_q    <= '0;
            sh_shift_q   <= '0;
            sh_control_q <= CTRL_SLL;
            s1_rd_q      <= '0;
            err_q        <= 1'b0;
            retired_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            sh_data_q    <= sh_data_d;
            sh_shift_q   <= sh_shift_d;
            sh_control_q <= sh_control_d;
            s1_rd_q      <= s1_rd_d;
            err_q        <= err_d;
            retired_q    <= retired_d;
        end
    end

    // Slot S2: captures the shifter result alongside the destination from S1.
    pipe_slot #(
        .Width (DATA_W + RD_W)
    ) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s1_valid_q),
        .ready_o (s2_free),
        .data_i  ({s1_rd_q, sh_out}),
        .valid_o (wb_valid),
        .ready_i (wb_ready),
        .data_o  ({wb_rd, wb_data})
    );

    assign sh_data     = sh_data_q;
    assign sh_shift    = sh_shift_q;
    assign sh_control  = sh_control_q;
    assign err_illegal = err_q;
    assign retired     = retired_q;

    // s1_adv equals the S2 upstream transfer; kept as a named term for readability.
    logic unused_adv;
    assign unused_adv = s1_adv;

endmodule

// File: tb/tb_shift_issue.sv
// Self-checking bench for shift_issue: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_shift_issue;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 16;
    localparam int unsigned RD_W   = 3;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic              in_use_imm;
    logic [3:0]        in_imm;
    logic [DATA_W-1:0] in_rs_val;
    logic [DATA_W-1:0] in_rt_val;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] sh_data;
    logic [AMT_W-1:0]  sh_shift;
    logic [1:0]        sh_control;
    logic [DATA_W-1:0] sh_out;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              err_illegal;
    logic [CNT_W-1:0]  retired;

    always #5 clk = ~clk;

    shift_issue #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_use_imm  (in_use_imm),
        .in_imm      (in_imm),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .in_rd       (in_rd),
        .sh_data     (sh_data),
        .sh_shift    (sh_shift),
        .sh_control  (sh_control),
        .sh_out      (sh_out),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .err_illegal (err_illegal),
        .retired     (retired)
    );

    // Behavioural 16-bit shifter: 0 SLL, 1 SRL, 2 SRA, 3 ROR.
    function automatic logic [15:0] do_shift(input logic [1:0] ctrl, input logic [15:0] d,
                                             input int amt);
        int v;
        int a;
        a = (amt >= 16) ? 16 : amt;
        case (ctrl)
            2'd0: v = (a >= 16) ? 0 : (int'(d) << a);
            2'd1: v = (a >= 16) ? 0 : (int'(d) >> a);
            2'd2: begin
                v = int'($signed(d));
                v = v >>> a;
            end
            default: begin
                a = amt % 16;
                v = (int'(d) >> a) | (int'(d) << (16 - a));
            end
        endcase
        return v[15:0];
    endfunction

    assign sh_out = do_shift(sh_control, sh_data, int'(sh_shift));

    function automatic int ref_amount(input logic [2:0] op, input logic ui, input logic [3:0] imm,
                                      input logic [15:0] rt);
        if (ui) return int'(imm);
        if (op[1:0] == 2'd3) return int'(rt) % 16;
        return (int'(rt) > 16) ? 16 : int'(rt);
    endfunction

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  rd;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic        ui;
        logic [3:0]  imm;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [2:0]  rd;
        logic [15:0] e_shift;
        logic [1:0]  e_ctrl;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[12];
    exp_t q[$];
    int   n_tests;
    int   n_fail;
    int   exp_ret;
    int   n_xfer;
    bit   last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic tick();
        bit          acc;
        bit          xfer;
        logic [2:0]  op;
        logic        ui;
        logic [3:0]  imm;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [2:0]  rd;
        logic [15:0] pre_data;
        logic [15:0] pre_shift;
        logic [1:0]  pre_ctrl;
        exp_t        e;
        int          amt;
        #1;
        acc  = in_valid && in_ready;
        xfer = wb_valid && wb_ready;
        op = in_op; ui = in_use_imm; imm = in_imm; rs = in_rs_val; rt = in_rt_val; rd = in_rd;
        if (q.size() == 0) chk("idle_wb_valid", wb_valid, 1'b0);
        if (q.size() >= 2) begin
            chk("full_wb_valid", wb_valid, 1'b1);
            chk("full_in_ready", in_ready, wb_ready);
        end else begin
            chk("in_ready", in_ready, 1'b1);
        end
        if (xfer) begin
            n_xfer++;
            exp_ret++;
            if (q.size() == 0) begin
                chk("spurious_wb", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", wb_rd, e.rd);
            end
        end
        pre_data = sh_data; pre_shift = sh_shift; pre_ctrl = sh_control;
        @(posedge clk);
        @(negedge clk);
        last_acc = acc;
        chk("retired", retired, exp_ret % 256);
        chk("err_illegal", err_illegal, acc && op[2]);
        if (acc && !op[2]) begin
            amt = ref_amount(op, ui, imm, rt);
            chk("sh_shift", sh_shift, amt);
            chk("sh_control", sh_control, op[1:0]);
            chk("sh_data", sh_data, rs);
            e.data = do_shift(op[1:0], rs, amt);
            e.rd   = rd;
            q.push_back(e);
        end else begin
            chk("sh_hold", {sh_data, sh_shift}, {pre_data, pre_shift});
            chk("sh_ctrl_hold", sh_control, pre_ctrl);
        end
    endtask

    task automatic offer(input logic [2:0] op, input logic ui, input logic [3:0] imm,
                         input logic [15:0] rs, input logic [15:0] rt, input logic [2:0] rd);
        bit done;
        done = 0;
        in_valid = 1'b1; in_op = op; in_use_imm = ui; in_imm = imm;
        in_rs_val = rs; in_rt_val = rt; in_rd = rd;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            done = last_acc;
        end
        if (!done) chk("offer_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic offer_rand_legal();
        offer(3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              16'($urandom), 16'($urandom_range(0, 40)), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int xbase;
        n_tests = 0; n_fail = 0; exp_ret = 0; n_xfer = 0; last_acc = 0;
        in_valid = 0; in_op = 0; in_use_imm = 0; in_imm = 0;
        in_rs_val = 0; in_rt_val = 0; in_rd = 0; wb_ready = 1;
        rst_n = 0;

        vecs[0]  = '{3'b000, 1, 4'd4,  16'h0003, 16'hFFFF, 3'd1, 16'd4,  2'd0, 16'h0030};
        vecs[1]  = '{3'b001, 0, 4'd0,  16'hFFFF, 16'd20,   3'd2, 16'd16, 2'd1, 16'h0000};
        vecs[2]  = '{3'b011, 0, 4'd0,  16'h1234, 16'd18,   3'd3, 16'd2,  2'd3, 16'h048D};
        vecs[3]  = '{3'b010, 0, 4'd0,  16'h8000, 16'd20,   3'd4, 16'd16, 2'd2, 16'hFFFF};
        vecs[4]  = '{3'b010, 1, 4'd4,  16'h8000, 16'd0,    3'd5, 16'd4,  2'd2, 16'hF800};
        vecs[5]  = '{3'b000, 0, 4'd0,  16'h00FF, 16'd16,   3'd6, 16'd16, 2'd0, 16'h0000};
        vecs[6]  = '{3'b011, 1, 4'd8,  16'h12AB, 16'd99,   3'd7, 16'd8,  2'd3, 16'hAB12};
        vecs[7]  = '{3'b001, 1, 4'd0,  16'hBEEF, 16'd5,    3'd0, 16'd0,  2'd1, 16'hBEEF};
        vecs[8]  = '{3'b000, 0, 4'd0,  16'h0001, 16'd15,   3'd1, 16'd15, 2'd0, 16'h8000};
        vecs[9]  = '{3'b011, 0, 4'd0,  16'hC0DE, 16'd16,   3'd2, 16'd0,  2'd3, 16'hC0DE};
        vecs[10] = '{3'b010, 0, 4'd0,  16'h7FF0, 16'd3,    3'd3, 16'd3,  2'd2, 16'h0FFE};
        vecs[11] = '{3'b011, 1, 4'd15, 16'h0001, 16'd0,    3'd4, 16'd15, 2'd3, 16'h0002};

        // Reset state.
        #12;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sh", {sh_data, sh_shift, sh_control}, 34'd0);
        chk("rst_wb", {wb_data, wb_rd}, 19'd0);
        chk("rst_err_ret", {err_illegal, retired}, 9'd0);
        @(negedge clk);
        rst_n = 1;

        // Directed vectors, one op at a time.
        for (int i = 0; i < 12; i++) begin
            offer(vecs[i].op, vecs[i].ui, vecs[i].imm, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            chk("vec_sh_shift", sh_shift, vecs[i].e_shift);
            chk("vec_sh_control", sh_control, vecs[i].e_ctrl);
            chk("vec_sh_data", sh_data, vecs[i].rs);
            tick();
            chk("vec_wb_valid", wb_valid, 1'b1);
            chk("vec_wb_data", wb_data, vecs[i].e_data);
            chk("vec_wb_rd", wb_rd, vecs[i].rd);
            tick();
            chk("vec_wb_drain", wb_valid, 1'b0);
        end
        chk("vec_retired", retired, 8'd12);

        // Back-pressure: two ops fill both slots, third stalls.
        base = exp_ret;
        wb_ready = 0;
        offer(3'b000, 1, 4'd1, 16'h0101, 16'd0, 3'd1);
        offer(3'b001, 1, 4'd2, 16'h0202, 16'd0, 3'd2);
        in_valid = 1; in_op = 3'b010; in_use_imm = 1; in_imm = 4'd3;
        in_rs_val = 16'h8303; in_rt_val = 0; in_rd = 3'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_stall", last_acc, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_sh_hold", sh_data, 16'h0202);
            chk("bp_wb_hold", wb_data, 16'h0202);
        end
        wb_ready = 1;
        offer(3'b010, 1, 4'd3, 16'h8303, 16'd0, 3'd3);
        offer(3'b011, 1, 4'd4, 16'h0404, 16'd0, 3'd4);
        tick();
        tick();
        chk("bp_retire_rate", retired, (base + 4) % 256);
        tick();

        // Illegal op between two legal ones.
        base = exp_ret;
        xbase = n_xfer;
        offer(3'b000, 1, 4'd2, 16'h0011, 16'd0, 3'd5);
        offer(3'b100, 1, 4'd2, 16'h0022, 16'd0, 3'd6);
        chk("ill_err_pulse", err_illegal, 1'b1);
        offer(3'b001, 1, 4'd1, 16'h0044, 16'd0, 3'd7);
        chk("ill_err_clear", err_illegal, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("ill_xfers", n_xfer - xbase, 2);
        chk("ill_retired", retired, (base + 2) % 256);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            wb_ready   = ($urandom_range(0, 9) < 7);
            in_op      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                                     : 3'($urandom_range(0, 3));
            in_use_imm = 1'($urandom_range(0, 1));
            in_imm     = 4'($urandom_range(0, 15));
            in_rs_val  = 16'($urandom);
            in_rt_val  = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            in_rd      = 3'($urandom_range(0, 7));
            tick();
        end
        in_valid = 0;
        wb_ready = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("rand_drained", q.size(), 0);

        // Reset while both slots are full.
        wb_ready = 0;
        offer_rand_legal();
        offer_rand_legal();
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_sh", {sh_data, sh_shift, sh_control}, 34'd0);
        chk("mid_rst_wb", {wb_data, wb_rd}, 19'd0);
        chk("mid_rst_err_ret", {err_illegal, retired}, 9'd0);
        q.delete();
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1;
        wb_ready = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_rst_no_wb", retired, 8'd0);

        // Retired counter wrap.
        for (int k = 0; k < 255; k++) offer_rand_legal();
        tick();
        tick();
        chk("wrap_255", retired, 8'd255);
        offer_rand_legal();
        tick();
        tick();
        chk("wrap_0", retired, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
